// File: rtl/usb2_phy_pkg.sv
// Shared USB2 PHY constants: idle line level, bit-stuff run length
// and a width helper for the decoded-ones counter.
package usb2_phy_pkg;

    // Idle J line level; the TX encoder also resets to this level.
    localparam logic LINE_J = 1'b1;

    // Consecutive decoded 1s after which a stuffed 0 follows.
    localparam int USB_STUFF_LEN = 6;

    // Bits needed to count 0..stuff_len inclusive.
    function automatic int ones_cnt_w(input int stuff_len);
        return $clog2(stuff_len + 1);
    endfunction

endpackage

// File: rtl/nrzi_rx_decoder_if.sv
// Bit-stream bundle: recovered line bit in, decoded bit out.
// Ports: din/din_valid (to decoder), dout/dout_valid/stuff_err (from it).
interface nrzi_rx_decoder_if;

    logic din;
    logic din_valid;
    logic dout;
    logic dout_valid;
    logic stuff_err;

    // Producer of line bits, consumer of decoded bits.
    modport master (
        output din,
        output din_valid,
        input  dout,
        input  dout_valid,
        input  stuff_err
    );

    // The decoder itself.
    modport slave (
        input  din,
        input  din_valid,
        output dout,
        output dout_valid,
        output stuff_err
    );

endinterface

// File: rtl/nrzi_bit_unstuffer.sv
// Removes stuffed 0s after STUFF_LEN decoded 1s and flags violations.
// Ports: clk, rst, clear, bit_valid/bit_in -> dout, dout_valid, stuff_err.
module nrzi_bit_unstuffer
    import usb2_phy_pkg::*;
#(
    parameter int STUFF_LEN = USB_STUFF_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic bit_valid,
    input  logic bit_in,
    output logic dout,
    output logic dout_valid,
    output logic stuff_err
);

    localparam int CNT_W = ones_cnt_w(STUFF_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STUFF_LEN);

    logic [CNT_W-1:0] ones_cnt_q, ones_cnt_d;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             stuff_err_q, stuff_err_d;

    always_comb begin
        ones_cnt_d   = ones_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        stuff_err_d  = 1'b0;
        if (clear) begin
            ones_cnt_d = '0;
            dout_d     = 1'b0;
        end else if (bit_valid) begin
            if (ones_cnt_q == CNT_MAX) begin
                // Expected stuffed 0: drop it. A 1 here is a violation;
                // the counter stays saturated so later 1s also flag.
                if (bit_in) begin
                    stuff_err_d = 1'b1;
                end else begin
                    ones_cnt_d = '0;
                end
            end else begin
                dout_d       = bit_in;
                dout_valid_d = 1'b1;
                ones_cnt_d   = bit_in ? ones_cnt_q + 1'b1 : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ones_cnt_q   <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            stuff_err_q  <= 1'b0;
        end else begin
            ones_cnt_q   <= ones_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            stuff_err_q  <= stuff_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign stuff_err  = stuff_err_q;

endmodule

// File: rtl/nrzi_rx_decoder.sv
// NRZI receive decoder: no transition -> 1, transition -> 0, then unstuff.
// Ports: clk, rst, clear, rx (slave: din/din_valid in, dout/valid/err out).
module nrzi_rx_decoder
    import usb2_phy_pkg::*;
#(
    parameter int STUFF_LEN = USB_STUFF_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    nrzi_rx_decoder_if.slave   rx
);

    logic prev_level_q, prev_level_d;
    logic dec_bit;

    // Compare against the previous line level, which starts at idle J.
    assign dec_bit = ~(rx.din ^ prev_level_q);

    always_comb begin
        prev_level_d = prev_level_q;
        if (clear) begin
            prev_level_d = LINE_J;
        end else if (rx.din_valid) begin
            // Stuffed and error bits still move the line history.
            prev_level_d = rx.din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_level_q <= LINE_J;
        end else begin
            prev_level_q <= prev_level_d;
        end
    end

    nrzi_bit_unstuffer #(
        .STUFF_LEN (STUFF_LEN)
    ) u_unstuff (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .bit_valid  (rx.din_valid),
        .bit_in     (dec_bit),
        .dout       (rx.dout),
        .dout_valid (rx.dout_valid),
        .stuff_err  (rx.stuff_err)
    );

endmodule

// File: tb/tb_nrzi_rx_decoder.sv
// Self-checking bench for nrzi_rx_decoder: directed scenarios plus
// randomized line streams against a bit-level reference model.
module tb_nrzi_rx_decoder;

    localparam int SL = 6;

    logic clk;
    logic rst;
    logic clear;

    int n_tests;
    int n_fail;

    // Reference model state: last line level, current decoded-ones run.
    logic m_prev;
    int   m_run;
    logic m_dout;

    logic e_dout, e_dv, e_err;

    nrzi_rx_decoder_if bus ();

    nrzi_rx_decoder #(
        .STUFF_LEN (SL)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .rx    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus, advance the model, and return the
    // outputs expected one cycle later (sampled 1 ns after the edge).
    task automatic drive(input logic v, input logic d, input logic c,
                         input logic r, output logic x_dout,
                         output logic x_dv, output logic x_err);
        logic b;
        @(negedge clk);
        bus.din       = d;
        bus.din_valid = v;
        clear         = c;
        rst           = r;
        x_dv  = 1'b0;
        x_err = 1'b0;
        if (r || c) begin
            m_prev = 1'b1;
            m_run  = 0;
            m_dout = 1'b0;
        end else if (v) begin
            b      = (d == m_prev);
            m_prev = d;
            if (m_run == SL) begin
                if (b) x_err = 1'b1;
                else   m_run = 0;
            end else begin
                m_dout = b;
                x_dv   = 1'b1;
                m_run  = b ? m_run + 1 : 0;
            end
        end
        x_dout = m_dout;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1, e_dout, e_dv, e_err);
        drive(1'b0, 1'b0, 1'b0, 1'b1, e_dout, e_dv, e_err);
        n_tests++;
        if ({bus.dout, bus.dout_valid, bus.stuff_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset: got %b%b%b want 000",
                     bus.dout, bus.dout_valid, bus.stuff_err);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, e_dout, e_dv, e_err);
    endtask

    task automatic test_sync();
        logic [7:0] lvl;
        logic [7:0] want;
        lvl  = 8'b00101010;
        want = 8'b10000000;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, lvl[i], 1'b0, 1'b0, e_dout, e_dv, e_err);
            n_tests++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== want[i] ||
                bus.stuff_err !== 1'b0 || bus.dout !== e_dout) begin
                n_fail++;
                $display("FAIL sync[%0d]: got d=%b v=%b e=%b want d=%b v=1 e=0",
                         i, bus.dout, bus.dout_valid, bus.stuff_err, want[i]);
            end
        end
    endtask

    task automatic test_stuff();
        int ones;
        ones = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, e_dout, e_dv, e_err);
        // Six 1s (constant J), stuffed transition, then one more 1.
        for (int i = 0; i < 8; i++) begin
            logic d;
            d = (i < 6) ? 1'b1 : 1'b0;
            drive(1'b1, d, 1'b0, 1'b0, e_dout, e_dv, e_err);
            if (bus.dout_valid && bus.dout) ones++;
            n_tests++;
            if (bus.dout_valid !== e_dv || bus.stuff_err !== e_err ||
                bus.dout !== e_dout) begin
                n_fail++;
                $display("FAIL stuff[%0d]: got d=%b v=%b e=%b want d=%b v=%b e=%b",
                         i, bus.dout, bus.dout_valid, bus.stuff_err,
                         e_dout, e_dv, e_err);
            end
        end
        n_tests++;
        if (ones !== 7) begin
            n_fail++;
            $display("FAIL stuff_ones: got %0d want 7", ones);
        end
    endtask

    task automatic test_violation();
        int ones;
        int errs;
        ones = 0;
        errs = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, e_dout, e_dv, e_err);
        // Eight constant levels: six 1s, then two violations, then a drop.
        for (int i = 0; i < 9; i++) begin
            logic d;
            d = (i < 8) ? 1'b1 : 1'b0;
            drive(1'b1, d, 1'b0, 1'b0, e_dout, e_dv, e_err);
            if (bus.dout_valid && bus.dout) ones++;
            if (bus.stuff_err) errs++;
            n_tests++;
            if (bus.dout_valid !== e_dv || bus.stuff_err !== e_err ||
                bus.dout !== e_dout) begin
                n_fail++;
                $display("FAIL viol[%0d]: got d=%b v=%b e=%b want d=%b v=%b e=%b",
                         i, bus.dout, bus.dout_valid, bus.stuff_err,
                         e_dout, e_dv, e_err);
            end
        end
        n_tests++;
        if (ones !== 6 || errs !== 2) begin
            n_fail++;
            $display("FAIL viol_count: got ones=%0d errs=%0d want 6 2",
                     ones, errs);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] lvl;
        logic [7:0] got;
        int k;
        lvl = 8'b00101010;
        got = '0;
        k   = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, e_dout, e_dv, e_err);
        for (int i = 0; i < 24; i++) begin
            logic v;
            logic d;
            v = (i % 3 == 0);
            // Gap cycles carry junk levels that must not affect history.
            d = v ? lvl[i/3] : 1'($urandom);
            drive(v, d, 1'b0, 1'b0, e_dout, e_dv, e_err);
            if (bus.dout_valid && k < 8) begin
                got[k] = bus.dout;
                k++;
            end
            n_tests++;
            if (bus.dout_valid !== v || bus.stuff_err !== 1'b0 ||
                bus.dout !== e_dout) begin
                n_fail++;
                $display("FAIL gaps[%0d]: got d=%b v=%b e=%b want d=%b v=%b e=0",
                         i, bus.dout, bus.dout_valid, bus.stuff_err, e_dout, v);
            end
        end
        n_tests++;
        if (got !== 8'b10000000) begin
            n_fail++;
            $display("FAIL gaps_seq: got %b want 10000000", got);
        end
    endtask

    task automatic test_clear();
        int ones;
        ones = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, e_dout, e_dv, e_err);
        for (int i = 0; i < 5; i++)
            drive(1'b1, 1'b1, 1'b0, 1'b0, e_dout, e_dv, e_err);
        drive(1'b1, 1'b0, 1'b1, 1'b0, e_dout, e_dv, e_err);
        n_tests++;
        if ({bus.dout, bus.dout_valid, bus.stuff_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL clear_out: got %b%b%b want 000",
                     bus.dout, bus.dout_valid, bus.stuff_err);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, e_dout, e_dv, e_err);
        n_tests++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_first: got d=%b v=%b want d=0 v=1",
                     bus.dout, bus.dout_valid);
        end
        // A full six-1 run after clear must not be cut short.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, e_dout, e_dv, e_err);
            if (bus.dout_valid && bus.dout) ones++;
        end
        n_tests++;
        if (ones !== 6) begin
            n_fail++;
            $display("FAIL clear_run: got %0d ones want 6", ones);
        end
    endtask

    task automatic test_rst_mid();
        drive(1'b0, 1'b0, 1'b0, 1'b1, e_dout, e_dv, e_err);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b1, 1'b0, 1'b0, e_dout, e_dv, e_err);
        drive(1'b1, 1'b0, 1'b0, 1'b1, e_dout, e_dv, e_err);
        n_tests++;
        if ({bus.dout, bus.dout_valid, bus.stuff_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_mid_out: got %b%b%b want 000",
                     bus.dout, bus.dout_valid, bus.stuff_err);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, e_dout, e_dv, e_err);
        n_tests++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_first: got d=%b v=%b want d=1 v=1",
                     bus.dout, bus.dout_valid);
        end
    endtask

    task automatic test_random();
        logic lvl;
        lvl = 1'b1;
        for (int i = 0; i < 600; i++) begin
            logic v;
            logic c;
            logic r;
            v = ($urandom_range(0, 9) < 8);
            c = ($urandom_range(0, 59) == 0);
            r = ($urandom_range(0, 119) == 0);
            // Mostly hold the level so long 1-runs and stuffing occur.
            if ($urandom_range(0, 3) == 0) lvl = ~lvl;
            drive(v, lvl, c, r, e_dout, e_dv, e_err);
            n_tests++;
            if (bus.dout_valid !== e_dv || bus.stuff_err !== e_err ||
                bus.dout !== e_dout) begin
                n_fail++;
                $display("FAIL rand[%0d]: got d=%b v=%b e=%b want d=%b v=%b e=%b",
                         i, bus.dout, bus.dout_valid, bus.stuff_err,
                         e_dout, e_dv, e_err);
            end
        end
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        m_prev        = 1'b1;
        m_run         = 0;
        m_dout        = 1'b0;
        rst           = 1'b1;
        clear         = 1'b0;
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        test_reset();
        test_sync();
        test_stuff();
        test_violation();
        test_gaps();
        test_clear();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
